sc_lane_rotator_bank: RTL and testbench
=======================================

Name: sc_lane_rotator_bank

Overview:
- Bank of LANES independent background-row registers, each WIDTH bits, for the Frogger playfield (river/road lanes).
- Each lane rotates autonomously left or right at its own programmable rate, derived from a per-lane period counter.
- Emits a per-lane step pulse and a full-revolution wrap pulse for the collision and scoring logic.
- Generalises the single-row background register: multiple lanes, a built-in rate prescaler, and position tracking.

Parameters:
- WIDTH, 8, bits per lane (≥2)
- LANES, 4, number of lanes (≥1)
- PERIODWIDTH, 4, width of each lane's period register/counter
- INIT_VALUE, {LANES*WIDTH}'b0, data loaded on reset/clear; lane i uses bits [i*WIDTH +: WIDTH]
- DEFAULT_PERIOD, 0, period value loaded into every lane on reset

Ports:
- SC_LaneRot_CLOCK_50  in  1  system clock
- SC_LaneRot_RESET_InHigh  in  1  synchronous, active-high reset
- SC_LaneRot_clear_InLow  in  1  global data clear, active low
- SC_LaneRot_enable_In  in  1  global run enable
- SC_LaneRot_load_InLow  in  1  load data into the addressed lane, active low
- SC_LaneRot_periodwr_InLow  in  1  write period of the addressed lane, active low
- SC_LaneRot_addr_In  in  clog2(LANES) (min 1)  lane address for load/periodwr
- SC_LaneRot_data_InBUS  in  WIDTH  load data
- SC_LaneRot_period_InBUS  in  PERIODWIDTH  period value
- SC_LaneRot_mode_InBUS  in  2*LANES  per-lane mode: 00 hold, 01 rotate left, 10 rotate right, 11 hold
- SC_LaneRot_data_OutBUS  out  LANES*WIDTH  lane contents, registered
- SC_LaneRot_step_OutBUS  out  LANES  one-cycle pulse, registered with the rotation
- SC_LaneRot_wrap_OutBUS  out  LANES  one-cycle pulse on a full revolution

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high, sampled only on the rising edge.
- Reset state:
  - data = INIT_VALUE
  - period = DEFAULT_PERIOD
  - counters = 0, positions = 0
  - step = 0, wrap = 0
- Per-lane priority each edge: reset > clear > load/periodwr (addressed lane only) > rotation.
- Clear (low): data = INIT_VALUE, counter = 0, position = 0 for all lanes. Periods are kept. No step or wrap.
- Load (addressed lane): data = data_InBUS, counter = 0, position = 0, no step that cycle.
- Periodwr (addressed lane): period = period_InBUS, counter = 0.
  - Load and periodwr in the same cycle both take effect.
  - Clear overrides load but still allows periodwr.
- Run condition: enable = 1 and mode ∈ {01, 10}.
  - counter == period → counter = 0, rotate once, step = 1.
  - Otherwise counter += 1.
  - Period P gives one step every P+1 cycles; P = 0 steps every cycle.
- Hold (mode 00/11 or enable = 0): data, counter and position frozen; step = 0.
- Rotation:
  - Left: {d[W-2:0], d[W-1]}, position +1.
  - Right: {d[0], d[W-1:1]}, position −1.
  - Position is modulo WIDTH.
- Wrap: pulses in the same cycle as the step when position goes WIDTH-1→0 (left) or 0→WIDTH-1 (right).
- Mode change mid-count: the counter continues and the new direction applies at the next step.
- Latency: data, step and wrap all update on the edge where the counter matches.
- step and wrap are pulses; they deassert the next cycle unless re-triggered.
- Out-of-range addr (LANES not a power of 2): load/periodwr ignored.

Decomposition:
- Package sc_lane_rotator_pkg:
  - mode constants MODE_HOLD0/LEFT/RIGHT/HOLD3
  - clog2 function
  - lane-slice helper
- Sub-module sc_lane_rotator_cell: one lane holding data, period, counter and position. Instantiated LANES times via generate; the top decodes the address and flattens the buses.

Test Plan (W=8, LANES=4, PERIODWIDTH=4, INIT=0, DEFAULT_PERIOD=0):
1. Assert reset for 1 edge with lanes previously nonzero → data_OutBUS = 0, step = 0, wrap = 0 after that edge. Output is unchanged before the edge, confirming synchronous reset.
2. Lane 2: load 0x81, period 2, mode 01, enable = 1 → data 0x81 for 2 cycles, then 0x03, 3 cycles later 0x06. step[2] pulses every 3rd cycle.
3. Lane 0: load 0x01, period 0, mode 10 → next edge 0x80 with step[0] = 1 and wrap[0] = 1 (position 0→7), then 0x40, 0x20… with no further wrap for 7 steps.
4. Lane 1: load 0xA5, mode 01, period 0 → after 8 steps data = 0xA5 again and wrap[1] pulses on the 8th step only.
5. Clear low with load to lane 3 of 0xFF in the same cycle → lane 3 = 0x00. A simultaneous periodwr of 5 is retained, shown by lane 3 stepping every 6 cycles afterwards.
6. Enable = 0 mid-count, or mode 11 → data, step and counter frozen for 10 cycles. On re-enable the next step occurs after the remaining count, not a fresh period.

Source files
------------

// File: rtl/sc_lane_rotator_pkg.sv
// Shared definitions for the Frogger lane rotator bank: lane modes and
// elaboration-time helpers for address width and lane bus slicing.
package sc_lane_rotator_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD0 = 2'b00,
      MODE_LEFT  = 2'b01,
      MODE_RIGHT = 2'b10,
      MODE_HOLD3 = 2'b11
   } laneModeE;

   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span = 1;
      while (span < value) begin
         span = span * 2;
         result++;
      end
      return result;
   endfunction

   // LSB index of a lane inside a flattened LANES*WIDTH bus
   function automatic int laneBase(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/sc_lane_rotator_cell.sv
// One playfield lane: row data, rate period, prescale counter and rotation
// position, producing step and full-revolution wrap pulses.
module sc_lane_rotator_cell
   import sc_lane_rotator_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PERIODWIDTH = 4,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0,
   parameter logic [PERIODWIDTH-1:0] DEFAULT_PERIOD = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   load,
   input  logic                   periodWrite,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic [WIDTH-1:0]       loadData,
   input  logic [PERIODWIDTH-1:0] periodData,
   output logic [WIDTH-1:0]       data,
   output logic                   step,
   output logic                   wrap
);

   localparam int POSWIDTH = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
   localparam logic [POSWIDTH-1:0] POSLAST = POSWIDTH'(WIDTH - 1);

   laneModeE               laneMode;
   logic                   run;
   logic                   countMatch;
   logic [PERIODWIDTH-1:0] period;
   logic [PERIODWIDTH-1:0] count;
   logic [POSWIDTH-1:0]    position;

   assign laneMode   = laneModeE'(mode);
   assign run        = enable && (laneMode == MODE_LEFT || laneMode == MODE_RIGHT);
   assign countMatch = (count == period);

   // Period writes survive a clear; load or period write restarts the prescaler
   always_ff @(posedge clock) begin
      if (reset) begin
         data     <= INIT_VALUE;
         period   <= DEFAULT_PERIOD;
         count    <= '0;
         position <= '0;
         step     <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         step <= 1'b0;
         wrap <= 1'b0;
         if (periodWrite) begin
            period <= periodData;
         end
         if (clear) begin
            data     <= INIT_VALUE;
            count    <= '0;
            position <= '0;
         end else if (load) begin
            data     <= loadData;
            count    <= '0;
            position <= '0;
         end else if (periodWrite) begin
            count <= '0;
         end else if (run) begin
            if (countMatch) begin
               count <= '0;
               step  <= 1'b1;
               if (laneMode == MODE_LEFT) begin
                  data     <= {data[WIDTH-2:0], data[WIDTH-1]};
                  position <= (position == POSLAST) ? '0 : position + POSWIDTH'(1);
                  wrap     <= (position == POSLAST);
               end else begin
                  data     <= {data[0], data[WIDTH-1:1]};
                  position <= (position == '0) ? POSLAST : position - POSWIDTH'(1);
                  wrap     <= (position == '0);
               end
            end else begin
               count <= count + PERIODWIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/sc_lane_rotator_bank.sv
// Bank of independently rotating background lanes; decodes the shared
// load/period address and flattens per-lane outputs onto wide buses.
module sc_lane_rotator_bank
   import sc_lane_rotator_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int PERIODWIDTH = 4,
   parameter logic [LANES*WIDTH-1:0] INIT_VALUE = '0,
   parameter logic [PERIODWIDTH-1:0] DEFAULT_PERIOD = '0,
   localparam int ADDRWIDTH = (clog2(LANES) < 1) ? 1 : clog2(LANES)
) (
   input  logic                   SC_LaneRot_CLOCK_50,
   input  logic                   SC_LaneRot_RESET_InHigh,
   input  logic                   SC_LaneRot_clear_InLow,
   input  logic                   SC_LaneRot_enable_In,
   input  logic                   SC_LaneRot_load_InLow,
   input  logic                   SC_LaneRot_periodwr_InLow,
   input  logic [ADDRWIDTH-1:0]   SC_LaneRot_addr_In,
   input  logic [WIDTH-1:0]       SC_LaneRot_data_InBUS,
   input  logic [PERIODWIDTH-1:0] SC_LaneRot_period_InBUS,
   input  logic [2*LANES-1:0]     SC_LaneRot_mode_InBUS,
   output logic [LANES*WIDTH-1:0] SC_LaneRot_data_OutBUS,
   output logic [LANES-1:0]       SC_LaneRot_step_OutBUS,
   output logic [LANES-1:0]       SC_LaneRot_wrap_OutBUS
);

   logic clearActive;

   assign clearActive = !SC_LaneRot_clear_InLow;

   // Addresses beyond LANES-1 match no lane, so such writes are dropped
   for (genvar lane = 0; lane < LANES; lane++) begin : gLane
      localparam int BASE = laneBase(lane, WIDTH);

      logic loadHit;
      logic periodHit;

      assign loadHit   = !SC_LaneRot_load_InLow && (SC_LaneRot_addr_In == ADDRWIDTH'(lane));
      assign periodHit = !SC_LaneRot_periodwr_InLow && (SC_LaneRot_addr_In == ADDRWIDTH'(lane));

      sc_lane_rotator_cell #(
         .WIDTH          (WIDTH),
         .PERIODWIDTH    (PERIODWIDTH),
         .INIT_VALUE     (INIT_VALUE[BASE +: WIDTH]),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) uCell (
         .clock       (SC_LaneRot_CLOCK_50),
         .reset       (SC_LaneRot_RESET_InHigh),
         .clear       (clearActive),
         .load        (loadHit),
         .periodWrite (periodHit),
         .enable      (SC_LaneRot_enable_In),
         .mode        (SC_LaneRot_mode_InBUS[2*lane +: 2]),
         .loadData    (SC_LaneRot_data_InBUS),
         .periodData  (SC_LaneRot_period_InBUS),
         .data        (SC_LaneRot_data_OutBUS[BASE +: WIDTH]),
         .step        (SC_LaneRot_step_OutBUS[lane]),
         .wrap        (SC_LaneRot_wrap_OutBUS[lane])
      );
   end

endmodule

// File: tb/tb_sc_lane_rotator_bank.sv
// Self-checking bench for sc_lane_rotator_bank: vector table, directed
// multi-cycle sequences and random traffic against a position-based model.
module tb_sc_lane_rotator_bank;

   logic        clock = 1'b0;
   logic        reset;
   logic        clearN;
   logic        loadN;
   logic        periodwrN;
   logic [1:0]  addr;
   logic [7:0]  dataIn;
   logic [3:0]  periodIn;
   logic [7:0]  mode;
   logic        enable;
   logic [31:0] dataOut;
   logic [3:0]  stepOut;
   logic [3:0]  wrapOut;

   int testsRun = 0;
   int testsFailed = 0;

   // Model: lane data is the loaded base rotated left by the lane position
   int mBase[4];
   int mPos[4];
   int mPer[4];
   int mElapsed[4];
   logic [3:0] mStep;
   logic [3:0] mWrap;

   typedef struct packed {
      logic        clearN;
      logic        loadN;
      logic        periodwrN;
      logic [1:0]  addr;
      logic [7:0]  data;
      logic [3:0]  period;
      logic [7:0]  mode;
      logic        enable;
      logic [31:0] expData;
      logic [3:0]  expStep;
      logic [3:0]  expWrap;
   } vecT;

   vecT vecs[11];

   logic       rClear, rLoad, rPw, rEn;
   logic [1:0] rAddr;
   logic [7:0] rData, rMode;
   logic [3:0] rPer;

   always #5 clock = ~clock;

   sc_lane_rotator_bank dut (
      .SC_LaneRot_CLOCK_50       (clock),
      .SC_LaneRot_RESET_InHigh   (reset),
      .SC_LaneRot_clear_InLow    (clearN),
      .SC_LaneRot_enable_In      (enable),
      .SC_LaneRot_load_InLow     (loadN),
      .SC_LaneRot_periodwr_InLow (periodwrN),
      .SC_LaneRot_addr_In        (addr),
      .SC_LaneRot_data_InBUS     (dataIn),
      .SC_LaneRot_period_InBUS   (periodIn),
      .SC_LaneRot_mode_InBUS     (mode),
      .SC_LaneRot_data_OutBUS    (dataOut),
      .SC_LaneRot_step_OutBUS    (stepOut),
      .SC_LaneRot_wrap_OutBUS    (wrapOut)
   );

   function automatic logic [7:0] rotl8(input int v, input int k);
      int x;
      int s;
      x = v & 255;
      s = k % 8;
      return 8'(((x << s) | (x >> (8 - s))) & 255);
   endfunction

   function automatic logic [31:0] modelBus();
      logic [31:0] b;
      b = '0;
      for (int l = 0; l < 4; l++) begin
         b[8*l +: 8] = rotl8(mBase[l], mPos[l]);
      end
      return b;
   endfunction

   task automatic modelEdge();
      logic ld, pw, run;
      logic [1:0] m;
      for (int l = 0; l < 4; l++) begin
         ld  = !loadN && (addr == 2'(l));
         pw  = !periodwrN && (addr == 2'(l));
         m   = mode[2*l +: 2];
         run = enable && (m == 2'b01 || m == 2'b10);
         mStep[l] = 1'b0;
         mWrap[l] = 1'b0;
         if (reset) begin
            mBase[l] = 0; mPos[l] = 0; mPer[l] = 0; mElapsed[l] = 0;
         end else begin
            if (pw) mPer[l] = int'(periodIn);
            if (!clearN) begin
               mBase[l] = 0; mPos[l] = 0; mElapsed[l] = 0;
            end else if (ld) begin
               mBase[l] = int'(dataIn); mPos[l] = 0; mElapsed[l] = 0;
            end else if (pw) begin
               mElapsed[l] = 0;
            end else if (run) begin
               if (mElapsed[l] == mPer[l]) begin
                  mElapsed[l] = 0;
                  mStep[l] = 1'b1;
                  if (m == 2'b01) begin
                     mPos[l] = (mPos[l] + 1) % 8;
                     mWrap[l] = (mPos[l] == 0);
                  end else begin
                     mWrap[l] = (mPos[l] == 0);
                     mPos[l] = (mPos[l] + 7) % 8;
                  end
               end else begin
                  mElapsed[l] = mElapsed[l] + 1;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic c, input logic l, input logic p,
                                input logic [1:0] a, input logic [7:0] d,
                                input logic [3:0] per, input logic [7:0] m,
                                input logic e);
      clearN = c; loadN = l; periodwrN = p; addr = a;
      dataIn = d; periodIn = per; mode = m; enable = e;
      modelEdge();
      @(posedge clock);
      #1;
   endtask

   task automatic checkVal(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] eData,
                              input logic [3:0] eStep, input logic [3:0] eWrap);
      checkVal({name, ".data"}, dataOut, eData);
      checkVal({name, ".step"}, 32'(stepOut), 32'(eStep));
      checkVal({name, ".wrap"}, 32'(wrapOut), 32'(eWrap));
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd2, 8'h81, 4'd2, 8'h10, 1'b1, 32'h00810000, 4'h0, 4'h0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1, 32'h00810000, 4'h0, 4'h0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1, 32'h00810000, 4'h0, 4'h0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1, 32'h00030000, 4'h4, 4'h0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1, 32'h00030000, 4'h0, 4'h0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1, 32'h00030000, 4'h0, 4'h0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1, 32'h00060000, 4'h4, 4'h0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h01, 4'd0, 8'h12, 1'b1, 32'h00060001, 4'h0, 4'h0};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h12, 1'b1, 32'h00060080, 4'h1, 4'h1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h12, 1'b1, 32'h000C0040, 4'h5, 4'h0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h12, 1'b1, 32'h000C0020, 4'h1, 4'h0};

      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h00, 1'b0);
      checkOutput("resetState", 32'h0, 4'h0, 4'h0);

      // Synchronous reset: outputs hold until the next rising edge
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'hAA, 4'd0, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 8'h55, 4'd0, 8'h00, 1'b0);
      checkVal("preloadLanes", dataOut, 32'h000055AA);
      reset = 1'b1;
      #3;
      checkVal("resetBeforeEdge", dataOut, 32'h000055AA);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h00, 1'b0);
      checkOutput("resetAfterEdge", 32'h0, 4'h0, 4'h0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].clearN, vecs[i].loadN, vecs[i].periodwrN, vecs[i].addr,
                       vecs[i].data, vecs[i].period, vecs[i].mode, vecs[i].enable);
         checkOutput($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expStep, vecs[i].expWrap);
      end

      // Lane 1 full left revolution: wrap only on the eighth step
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 8'hA5, 4'd0, 8'h04, 1'b1);
      checkOutput("leftLoad", 32'h000CA520, 4'h0, 4'h0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h04, 1'b1);
         checkVal($sformatf("leftStep%0d", k), 32'(stepOut), 32'h2);
         checkVal($sformatf("leftWrap%0d", k), 32'(wrapOut[1]), (k == 7) ? 32'h1 : 32'h0);
      end
      checkVal("leftFullTurn", 32'(dataOut[15:8]), 32'hA5);

      // Clear beats load but keeps the period write of 5
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 4'd5, 8'h40, 1'b1);
      checkOutput("clearOverLoad", 32'h0, 4'h0, 4'h0);
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h40, 1'b1);
         checkVal($sformatf("period5Step%0d", k), 32'(stepOut), (k % 6 == 5) ? 32'h8 : 32'h0);
      end

      // Freeze via enable, then via mode 11; counting resumes where it stopped
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 8'h81, 4'd3, 8'h10, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b0);
         checkVal("enableFreezeData", 32'(dataOut[23:16]), 32'h81);
         checkVal("enableFreezeStep", 32'(stepOut), 32'h0);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1);
      checkVal("resumeNoStep", 32'(stepOut), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1);
      checkVal("resumeStep", 32'(stepOut), 32'h4);
      checkVal("resumeData", 32'(dataOut[23:16]), 32'h03);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h30, 1'b1);
         checkVal("mode11FreezeStep", 32'(stepOut), 32'h0);
      end
      checkVal("mode11FreezeData", 32'(dataOut[23:16]), 32'h03);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1);
      checkVal("mode11ResumeNoStep", 32'(stepOut), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 4'd0, 8'h10, 1'b1);
      checkVal("mode11ResumeStep", 32'(stepOut), 32'h4);
      checkVal("mode11ResumeData", 32'(dataOut[23:16]), 32'h06);

      for (int k = 0; k < 400; k++) begin
         reset  = ($urandom_range(0, 63) == 0);
         rClear = ($urandom_range(0, 31) != 0);
         rLoad  = ($urandom_range(0, 7) != 0);
         rPw    = ($urandom_range(0, 7) != 0);
         rAddr  = 2'($urandom_range(0, 3));
         rData  = 8'($urandom);
         rPer   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         rMode  = 8'($urandom);
         rEn    = ($urandom_range(0, 7) != 0);
         applyStimulus(rClear, rLoad, rPw, rAddr, rData, rPer, rMode, rEn);
         checkOutput($sformatf("random%0d", k), modelBus(), mStep, mWrap);
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
